// File: rtl/vga_tile_scanner_pkg.sv
// Shared VGA constants: raster timing, tile geometry, colours and the
// sideband tag carried alongside each pixel through the pipeline.
package vga_tile_scanner_pkg;

  localparam int CNT_W      = 10;
  localparam int TILE_SHIFT = 5;
  localparam int MAP_COLS   = 16;
  localparam int MAP_ROWS   = 15;

  localparam int VGA_H_VIS  = 640;
  localparam int VGA_H_FP   = 16;
  localparam int VGA_H_SYNC = 96;
  localparam int VGA_H_BP   = 48;
  localparam int VGA_V_VIS  = MAP_ROWS << TILE_SHIFT;
  localparam int VGA_V_FP   = 10;
  localparam int VGA_V_SYNC = 2;
  localparam int VGA_V_BP   = 33;

  localparam logic [11:0] RGB_BLACK  = 12'h000;
  localparam logic [11:0] RGB_BORDER = 12'h333;

  typedef struct packed {
    logic vis;
    logic inmap;
    logic hs;
    logic vs;
    logic origin;
  } sideband_t;

  // Idle tag keeps syncs deasserted while the pipeline refills after reset.
  localparam sideband_t SB_IDLE = '{vis: 1'b0, inmap: 1'b0, hs: 1'b1, vs: 1'b1, origin: 1'b0};

endpackage

// File: rtl/vga_tile_scanner_timing.sv
// Raster counters and the per-position flags derived from them.
module vga_tile_scanner_timing
  import vga_tile_scanner_pkg::*;
#(
  parameter int H_VIS  = VGA_H_VIS,
  parameter int H_FP   = VGA_H_FP,
  parameter int H_SYNC = VGA_H_SYNC,
  parameter int H_BP   = VGA_H_BP,
  parameter int V_VIS  = VGA_V_VIS,
  parameter int V_FP   = VGA_V_FP,
  parameter int V_SYNC = VGA_V_SYNC,
  parameter int V_BP   = VGA_V_BP
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pix_en,
  output logic [CNT_W-1:0] h_cnt,
  output logic [CNT_W-1:0] v_cnt,
  output logic             vis,
  output logic             hs_raw,
  output logic             vs_raw,
  output logic             origin
);

  localparam logic [CNT_W-1:0] H_VIS_L  = CNT_W'(H_VIS);
  localparam logic [CNT_W-1:0] H_SYNC_S = CNT_W'(H_VIS + H_FP);
  localparam logic [CNT_W-1:0] H_SYNC_E = CNT_W'(H_VIS + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_VIS + H_FP + H_SYNC + H_BP - 1);
  localparam logic [CNT_W-1:0] V_VIS_L  = CNT_W'(V_VIS);
  localparam logic [CNT_W-1:0] V_SYNC_S = CNT_W'(V_VIS + V_FP);
  localparam logic [CNT_W-1:0] V_SYNC_E = CNT_W'(V_VIS + V_FP + V_SYNC);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_VIS + V_FP + V_SYNC + V_BP - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pix_en) begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
      end else begin
        h_cnt <= h_cnt + 1'b1;
      end
    end
  end

  assign vis    = (h_cnt < H_VIS_L) && (v_cnt < V_VIS_L);
  assign hs_raw = !((h_cnt >= H_SYNC_S) && (h_cnt < H_SYNC_E));
  assign vs_raw = !((v_cnt >= V_SYNC_S) && (v_cnt < V_SYNC_E));
  assign origin = (h_cnt == '0) && (v_cnt == '0);

endmodule

// File: rtl/vga_tile_scanner.sv
// VGA front end: raster position -> map RAM address -> texture request,
// then the returned texel is muxed with border/blank colour and aligned syncs.
module vga_tile_scanner
  import vga_tile_scanner_pkg::*;
#(
  parameter logic [11:0] BORDER_RGB = RGB_BORDER,
  parameter int H_VIS  = VGA_H_VIS,
  parameter int H_FP   = VGA_H_FP,
  parameter int H_SYNC = VGA_H_SYNC,
  parameter int H_BP   = VGA_H_BP,
  parameter int V_VIS  = VGA_V_VIS,
  parameter int V_FP   = VGA_V_FP,
  parameter int V_SYNC = VGA_V_SYNC,
  parameter int V_BP   = VGA_V_BP
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pix_en,
  output logic [7:0]  ram_addr,
  input  logic [3:0]  ram_data,
  output logic [4:0]  tex_type,
  output logic [4:0]  tex_x,
  output logic [4:0]  tex_y,
  input  logic [11:0] tex_pixel,
  output logic        hs,
  output logic        vs,
  output logic [11:0] rgb,
  output logic        frame_start
);

  localparam logic [CNT_W-1:0] MAP_W = CNT_W'(MAP_COLS << TILE_SHIFT);

  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic             vis;
  logic             hs_raw;
  logic             vs_raw;
  logic             origin;
  sideband_t        sb_s0;
  sideband_t        sb_s1_reg;
  sideband_t        sb_s2_reg;

  vga_tile_scanner_timing #(
    .H_VIS (H_VIS),  .H_FP (H_FP),  .H_SYNC (H_SYNC),  .H_BP (H_BP),
    .V_VIS (V_VIS),  .V_FP (V_FP),  .V_SYNC (V_SYNC),  .V_BP (V_BP)
  ) u_timing (
    .clk    (clk),
    .rst_n  (rst_n),
    .pix_en (pix_en),
    .h_cnt  (h_cnt),
    .v_cnt  (v_cnt),
    .vis    (vis),
    .hs_raw (hs_raw),
    .vs_raw (vs_raw),
    .origin (origin)
  );

  assign sb_s0 = '{vis:    vis,
                   inmap:  vis && (h_cnt < MAP_W),
                   hs:     hs_raw,
                   vs:     vs_raw,
                   origin: origin};

  // Address and offsets launch together so ram_data lines up with tex_x/tex_y.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_addr  <= '0;
      tex_x     <= '0;
      tex_y     <= '0;
      sb_s1_reg <= SB_IDLE;
      sb_s2_reg <= SB_IDLE;
      rgb       <= RGB_BLACK;
      hs        <= 1'b1;
      vs        <= 1'b1;
    end else if (pix_en) begin
      ram_addr  <= {v_cnt[TILE_SHIFT+3:TILE_SHIFT], h_cnt[TILE_SHIFT+3:TILE_SHIFT]};
      tex_x     <= h_cnt[TILE_SHIFT-1:0];
      tex_y     <= v_cnt[TILE_SHIFT-1:0];
      sb_s1_reg <= sb_s0;
      sb_s2_reg <= sb_s1_reg;
      rgb       <= !sb_s2_reg.vis   ? RGB_BLACK  :
                   !sb_s2_reg.inmap ? BORDER_RGB : tex_pixel;
      hs        <= sb_s2_reg.hs;
      vs        <= sb_s2_reg.vs;
    end
  end

  // Not held by pix_en=0: the pulse lasts a single clk even when strobes are sparse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_start <= 1'b0;
    end else begin
      frame_start <= pix_en && sb_s2_reg.origin;
    end
  end

  assign tex_type = sb_s1_reg.inmap ? {1'b0, ram_data} : 5'd0;

endmodule

// File: tb/tb_vga_tile_scanner.sv
// Scoreboard bench: stimulus pushes expected outputs per pixel strobe, a monitor pops and compares.
module tb_vga_tile_scanner;

  localparam int HT = 800;
  localparam int VV = 72;
  localparam int VF = 2;
  localparam int VS = 2;
  localparam int VB = 2;
  localparam int VT = VV + VF + VS + VB;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pix_en = 1'b0;
  logic [7:0]  ram_addr;
  logic [3:0]  ram_data;
  logic [4:0]  tex_type;
  logic [4:0]  tex_x;
  logic [4:0]  tex_y;
  logic [11:0] tex_pixel;
  logic        hs;
  logic        vs;
  logic [11:0] rgb;
  logic        frame_start;

  always #5 clk = ~clk;

  vga_tile_scanner #(
    .BORDER_RGB (12'h333),
    .V_VIS (VV), .V_FP (VF), .V_SYNC (VS), .V_BP (VB)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pix_en      (pix_en),
    .ram_addr    (ram_addr),
    .ram_data    (ram_data),
    .tex_type    (tex_type),
    .tex_x       (tex_x),
    .tex_y       (tex_y),
    .tex_pixel   (tex_pixel),
    .hs          (hs),
    .vs          (vs),
    .rgb         (rgb),
    .frame_start (frame_start)
  );

  // Stub map RAM (combinational read) and stub Texture (registered on pix_en).
  assign ram_data = ram_addr[3:0] ^ ram_addr[7:4];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) tex_pixel <= '0;
    else if (pix_en) tex_pixel <= ~{tex_type[3:0], tex_x[3:0], tex_y[3:0]};
  end

  typedef struct packed {
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
    logic        fs;
    logic [9:0]  h;
    logic [9:0]  v;
  } out_t;

  typedef struct packed {
    logic [7:0] addr;
    logic [4:0] ty;
    logic [4:0] x;
    logic [4:0] y;
    logic [9:0] h;
    logic [9:0] v;
  } tex_t;

  localparam out_t OUT_RST = '{rgb: 12'h000, hs: 1'b1, vs: 1'b1, fs: 1'b0, h: 10'h3ff, v: 10'h3ff};
  localparam tex_t TEX_RST = '{addr: 8'h00, ty: 5'd0, x: 5'd0, y: 5'd0, h: 10'h3ff, v: 10'h3ff};

  out_t out_q[$];
  tex_t tex_q[$];
  out_t last_out;
  tex_t last_tex;
  int   mh, mv;
  int   tests = 0;
  int   fails = 0;
  int   cur_h, cur_v;
  int   rel_cnt, first_nz, fs_at, fs_cnt;
  int   hs_run, vs_run, last_hs_run, last_vs_run;
  int   hs_fall_first, hs_fall_last, line_period;
  logic prev_hs;

  function automatic out_t model_out(input int h, input int v);
    out_t o;
    logic vis, inmap;
    logic [3:0] ty;
    vis   = (h < 640) && (v < VV);
    inmap = vis && (h < 512);
    ty    = 4'((h / 32) % 16) ^ 4'((v / 32) % 16);
    o.rgb = !vis ? 12'h000 : (!inmap ? 12'h333 : ~{ty, 4'(h % 16), 4'(v % 16)});
    o.hs  = !((h >= 656) && (h < 752));
    o.vs  = !((v >= VV + VF) && (v < VV + VF + VS));
    o.fs  = (h == 0) && (v == 0);
    o.h   = 10'(h);
    o.v   = 10'(v);
    return o;
  endfunction

  function automatic tex_t model_tex(input int h, input int v);
    tex_t t;
    logic inmap;
    inmap  = (h < 512) && (v < VV);
    t.addr = {4'((v / 32) % 16), 4'((h / 32) % 16)};
    t.ty   = inmap ? {1'b0, t.addr[3:0] ^ t.addr[7:4]} : 5'd0;
    t.x    = 5'(h % 32);
    t.y    = 5'(v % 32);
    t.h    = 10'(h);
    t.v    = 10'(v);
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h at h=%0d v=%0d", nm, act, exp, cur_h, cur_v);
    end
  endtask

  // Scoreboard feed: one expected entry per strobe, from the bench's own raster model.
  initial forever begin
    @(posedge clk);
    if (rst_n && pix_en) begin
      out_q.push_back(model_out(mh, mv));
      tex_q.push_back(model_tex(mh, mv));
      if (mh == HT - 1) begin
        mh = 0;
        mv = (mv == VT - 1) ? 0 : mv + 1;
      end else begin
        mh = mh + 1;
      end
    end
  end

  // Monitor: pop on strobes, otherwise everything must stay frozen.
  initial forever begin
    logic pe;
    out_t eo;
    tex_t et;
    @(posedge clk);
    if (rst_n) begin
      pe = pix_en;
      #1;
      if (pe) begin
        if (out_q.size() == 0 || tex_q.size() == 0) begin
          chk("sb_empty", 32'(out_q.size()), 32'd1);
        end else begin
          eo = out_q.pop_front();
          et = tex_q.pop_front();
          rel_cnt++;
          cur_h = int'(eo.h); cur_v = int'(eo.v);
          chk("rgb", 32'(rgb), 32'(eo.rgb));
          chk("hs", 32'(hs), 32'(eo.hs));
          chk("vs", 32'(vs), 32'(eo.vs));
          chk("frame_start", 32'(frame_start), 32'(eo.fs));
          cur_h = int'(et.h); cur_v = int'(et.v);
          chk("ram_addr", 32'(ram_addr), 32'(et.addr));
          chk("tex_type", 32'(tex_type), 32'(et.ty));
          chk("tex_x", 32'(tex_x), 32'(et.x));
          chk("tex_y", 32'(tex_y), 32'(et.y));
          if (et.h == 10'd37 && et.v == 10'd70) begin
            chk("px37_70_addr", 32'(ram_addr), 32'h21);
            chk("px37_70_tx", 32'(tex_x), 32'd5);
            chk("px37_70_ty", 32'(tex_y), 32'd6);
            chk("px37_70_type", 32'(tex_type), 32'd3);
            $display("[TB] tex (37,70) addr=%h type=%0d x=%0d y=%0d", ram_addr, tex_type, tex_x, tex_y);
          end
          if (eo.v == 10'd70 && (eo.h == 10'd37 || eo.h == 10'd600 || eo.h == 10'd700)) begin
            cur_h = int'(eo.h); cur_v = 70;
            chk("px_rgb_dir", 32'(rgb), (eo.h == 10'd37) ? 32'hca9 : (eo.h == 10'd600) ? 32'h333 : 32'h0);
            $display("[TB] rgb (%0d,70) = %h", eo.h, rgb);
          end
          if (eo.v == 10'd73 && eo.h == 10'd10) begin
            chk("px10_73_rgb", 32'(rgb), 32'h0);
            $display("[TB] rgb (10,73) = %h", rgb);
          end
          if (rgb != 12'h000 && first_nz < 0) first_nz = rel_cnt;
          if (frame_start) begin
            fs_cnt++;
            if (fs_at < 0) fs_at = rel_cnt;
          end
          if (!hs) hs_run++;
          else if (hs_run > 0) begin last_hs_run = hs_run; hs_run = 0; end
          if (!vs) vs_run++;
          else if (vs_run > 0) begin last_vs_run = vs_run; vs_run = 0; end
          if (prev_hs && !hs) begin
            if (hs_fall_first < 0) hs_fall_first = rel_cnt;
            if (hs_fall_last >= 0) line_period = rel_cnt - hs_fall_last;
            hs_fall_last = rel_cnt;
          end
          prev_hs = hs;
          last_out = eo;
          last_tex = et;
        end
      end else begin
        chk("hold_rgb", 32'(rgb), 32'(last_out.rgb));
        chk("hold_hs", 32'(hs), 32'(last_out.hs));
        chk("hold_vs", 32'(vs), 32'(last_out.vs));
        chk("hold_fs", 32'(frame_start), 32'd0);
        chk("hold_addr", 32'(ram_addr), 32'(last_tex.addr));
        chk("hold_tx", 32'(tex_x), 32'(last_tex.x));
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    cur_h = -1; cur_v = -1;
    chk({tag, "_rgb"}, 32'(rgb), 32'h0);
    chk({tag, "_hs"}, 32'(hs), 32'd1);
    chk({tag, "_vs"}, 32'(vs), 32'd1);
    chk({tag, "_fs"}, 32'(frame_start), 32'd0);
    chk({tag, "_addr"}, 32'(ram_addr), 32'h0);
    chk({tag, "_type"}, 32'(tex_type), 32'h0);
    chk({tag, "_tx"}, 32'(tex_x), 32'h0);
    chk({tag, "_ty"}, 32'(tex_y), 32'h0);
    $display("[TB] reset check %s rgb=%h hs=%b vs=%b", tag, rgb, hs, vs);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    pix_en = 1'b0;
    rst_n  = 1'b0;
    out_q.delete();
    tex_q.delete();
    out_q.push_back(OUT_RST);
    out_q.push_back(OUT_RST);
    mh = 0; mv = 0;
    last_out = OUT_RST; last_tex = TEX_RST;
    rel_cnt = 0; first_nz = -1; fs_at = -1; fs_cnt = 0;
    hs_run = 0; vs_run = 0; last_hs_run = -1; last_vs_run = -1;
    hs_fall_first = -1; hs_fall_last = -1; line_period = -1;
    prev_hs = 1'b1;
    #1;
    check_reset_outputs(tag);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_sparse(input int n, input int period);
    for (int i = 0; i < n; i++) begin
      @(negedge clk) pix_en = 1'b1;
      @(negedge clk) pix_en = 1'b0;
      repeat (period - 2) @(negedge clk);
    end
  endtask

  task automatic run_cont(input int n);
    @(negedge clk) pix_en = 1'b1;
    repeat (n - 1) @(negedge clk);
    pix_en = 1'b0;
  endtask

  initial begin
    do_reset("por");
    // Sparse strobes across the first hsync, with a long stall mid-line.
    run_sparse(400, 4);
    repeat (50) @(negedge clk);
    run_sparse(600, 4);
    cur_h = -1; cur_v = -1;
    chk("first_rgb_lat", 32'(first_nz), 32'd3);
    chk("fs_lat", 32'(fs_at), 32'd3);
    chk("first_hs_fall", 32'(hs_fall_first), 32'd659);
    chk("hs_low_len", 32'(last_hs_run), 32'd96);
    run_cont(1700);
    chk("line_period", 32'(line_period), 32'd800);
    chk("fs_count_a", 32'(fs_cnt), 32'd1);
    $display("[TB] phase A done at model h=%0d v=%0d", mh, mv);
    do_reset("mid");
    run_cont(VT * HT + 10);
    cur_h = -1; cur_v = -1;
    chk("rst_fs_lat", 32'(fs_at), 32'd3);
    chk("rst_first_rgb", 32'(first_nz), 32'd3);
    chk("fs_count_b", 32'(fs_cnt), 32'd2);
    chk("vs_low_len", 32'(last_vs_run), 32'(VS * HT));
    chk("hs_low_len_b", 32'(last_hs_run), 32'd96);
    repeat (4) @(negedge clk);
    chk("sb_drain", 32'(out_q.size()), 32'd2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
